// File: rtl/tetris_pkg.sv
// Shared encodings for the Tetris control path: main FSM states, datapath
// command opcodes, move-scheduler states and the request arbiter.
package tetris_pkg;

    typedef enum logic [2:0] {
        GS_GEN      = 3'b000,
        GS_MOVE     = 3'b001,
        GS_LAND     = 3'b010,
        GS_NEWBOARD = 3'b011,
        GS_GAMEOVER = 3'b101
    } game_state_e;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_LEFT  = 3'd1,
        OP_RIGHT = 3'd2,
        OP_ROT   = 3'd3,
        OP_DOWN  = 3'd4
    } cmd_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_HOLD,
        S_LOCK
    } sched_state_e;

    typedef struct packed {
        logic grav;
        logic down;
        logic rot;
        logic left;
        logic right;
    } pend_t;

    // Fixed priority grav > down > rot > left > right; grav and down share one DOWN.
    function automatic cmd_op_e pick_cmd(input pend_t p, input logic allow_down);
        cmd_op_e op;
        op = OP_NONE;
        if (allow_down && (p.grav || p.down)) op = OP_DOWN;
        else if (p.rot)                       op = OP_ROT;
        else if (p.left)                      op = OP_LEFT;
        else if (p.right)                     op = OP_RIGHT;
        return op;
    endfunction

endpackage

// File: rtl/move_scheduler_grav_timer.sv
// Gravity timer: counts enabled cycles and pulses wrap on the cycle the
// count reaches PERIOD-1, returning to zero.
module grav_timer
    import tetris_pkg::*;
#(
    parameter int unsigned PERIOD = 50
) (
    input  logic clka,
    input  logic restart_n,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam int unsigned W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [W-1:0] cnt;

    assign wrap = en && !clr && (cnt == W'(PERIOD - 1));

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            cnt <= '0;
        end else if (clr || wrap) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/move_scheduler.sv
// Move scheduler: merges player requests and gravity into one command stream
// over a valid/done handshake. Optional lock delay: MOVE_SCHED_LOCK_DELAY_EN.
module move_scheduler
    import tetris_pkg::*;
#(
    parameter int unsigned DROP_PERIOD = 50,
    parameter int unsigned LOCK_CYCLES = 16
) (
    input  logic       clka,
    input  logic       restart_n,
    input  logic [2:0] fsm_state,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_rot,
    input  logic       btn_down,
    input  logic       cmd_done,
    input  logic       cmd_blocked,
    output logic       cmd_valid,
    output logic [2:0] cmd_op,
    output logic       placed,
    output logic       busy
);

    if (DROP_PERIOD < 2 || LOCK_CYCLES < 1) begin : g_param_check
        $error("move_scheduler: DROP_PERIOD must be >= 2 and LOCK_CYCLES >= 1");
    end

    sched_state_e state, state_next;
    cmd_op_e      op_q, op_next, pick;
    logic         valid_next, placed_next;
    pend_t        pend, pend_next, grant, req;
    logic         in_move, issue, lock_hold;
    logic         grav_en, grav_clr, grav_wrap;

`ifdef MOVE_SCHED_LOCK_DELAY_EN
    localparam int unsigned LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    logic [LW-1:0] lock_cnt, lock_cnt_next;
    logic          lock_ctx, lock_ctx_next;

    // lock_ctx marks a command issued from LOCK so its completion returns there.
    assign lock_hold = (state == S_LOCK) || ((state == S_ISSUE) && lock_ctx);
`else
    assign lock_hold = 1'b0;
`endif

    assign in_move = (fsm_state == GS_MOVE);
    assign grav_en = in_move && !lock_hold && ((state == S_IDLE) || (state == S_ISSUE));
    assign busy    = (state != S_IDLE);
    assign cmd_op  = op_q;

    grav_timer #(
        .PERIOD(DROP_PERIOD)
    ) u_grav_timer (
        .clka      (clka),
        .restart_n (restart_n),
        .en        (grav_en),
        .clr       (grav_clr),
        .wrap      (grav_wrap)
    );

    always_comb begin
        state_next  = state;
        op_next     = op_q;
        valid_next  = cmd_valid;
        placed_next = 1'b0;
        grav_clr    = !in_move;
        pick        = pick_cmd(pend, state != S_LOCK);
`ifdef MOVE_SCHED_LOCK_DELAY_EN
        lock_cnt_next = lock_cnt;
        lock_ctx_next = lock_ctx;
`endif

        case (state)
            S_IDLE: begin
                if (in_move && (pick != OP_NONE)) begin
                    op_next    = pick;
                    valid_next = 1'b1;
                    state_next = S_ISSUE;
`ifdef MOVE_SCHED_LOCK_DELAY_EN
                    lock_ctx_next = 1'b0;
`endif
                end
            end

            S_ISSUE: begin
                if (cmd_done) begin
                    valid_next = 1'b0;
                    op_next    = OP_NONE;
                    if (!in_move) begin
                        state_next = S_IDLE;
                    end else if ((op_q == OP_DOWN) && cmd_blocked) begin
`ifdef MOVE_SCHED_LOCK_DELAY_EN
                        if (lock_ctx) begin
                            placed_next = 1'b1;
                            state_next  = S_HOLD;
                        end else begin
                            lock_cnt_next = '0;
                            state_next    = S_LOCK;
                        end
`else
                        placed_next = 1'b1;
                        state_next  = S_HOLD;
`endif
                    end else begin
`ifdef MOVE_SCHED_LOCK_DELAY_EN
                        if (lock_ctx && (op_q != OP_DOWN)) begin
                            state_next = S_LOCK;
                            if (!cmd_blocked) lock_cnt_next = '0;
                        end else begin
                            state_next = S_IDLE;
                            if (lock_ctx) grav_clr = 1'b1;
                        end
`else
                        state_next = S_IDLE;
`endif
                    end
                end
            end

            S_HOLD: begin
                if (!in_move) state_next = S_IDLE;
            end

`ifdef MOVE_SCHED_LOCK_DELAY_EN
            S_LOCK: begin
                if (!in_move) begin
                    state_next = S_IDLE;
                end else if (pick != OP_NONE) begin
                    op_next       = pick;
                    valid_next    = 1'b1;
                    lock_ctx_next = 1'b1;
                    state_next    = S_ISSUE;
                end else if (lock_cnt == LW'(LOCK_CYCLES - 1)) begin
                    op_next       = OP_DOWN;
                    valid_next    = 1'b1;
                    lock_ctx_next = 1'b1;
                    state_next    = S_ISSUE;
                end else begin
                    lock_cnt_next = lock_cnt + 1'b1;
                end
            end
`endif

            default: state_next = S_IDLE;
        endcase

        issue       = (state != S_ISSUE) && (state_next == S_ISSUE);
        grant       = '0;
        grant.grav  = issue && (op_next == OP_DOWN);
        grant.down  = issue && (op_next == OP_DOWN);
        grant.rot   = issue && (op_next == OP_ROT);
        grant.left  = issue && (op_next == OP_LEFT);
        grant.right = issue && (op_next == OP_RIGHT);

        req.grav  = grav_wrap;
        req.down  = btn_down && !lock_hold;
        req.rot   = btn_rot;
        req.left  = btn_left;
        req.right = btn_right;
        if (!in_move || (state == S_HOLD)) req = '0;

        // A request in the grant cycle of the same bit survives the clear.
        pend_next = in_move ? ((pend & ~grant) | req) : '0;
    end

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            state     <= S_IDLE;
            op_q      <= OP_NONE;
            cmd_valid <= 1'b0;
            placed    <= 1'b0;
            pend      <= '0;
`ifdef MOVE_SCHED_LOCK_DELAY_EN
            lock_cnt  <= '0;
            lock_ctx  <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            op_q      <= op_next;
            cmd_valid <= valid_next;
            placed    <= placed_next;
            pend      <= pend_next;
`ifdef MOVE_SCHED_LOCK_DELAY_EN
            lock_cnt  <= lock_cnt_next;
            lock_ctx  <= lock_ctx_next;
`endif
        end
    end

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler (default build, DROP_PERIOD=6) with
// hand-computed cycle numbers relative to the MOVE entry cycle.
module tb_move_scheduler;
    import tetris_pkg::*;

    logic       clka;
    logic       restart_n;
    logic [2:0] fsm_state;
    logic       btn_left, btn_right, btn_rot, btn_down;
    logic       cmd_done, cmd_blocked;
    logic       cmd_valid;
    logic [2:0] cmd_op;
    logic       placed, busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int at, t0, m0, g0, g1;

    move_scheduler #(
        .DROP_PERIOD(6),
        .LOCK_CYCLES(3)
    ) dut (
        .clka        (clka),
        .restart_n   (restart_n),
        .fsm_state   (fsm_state),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_rot     (btn_rot),
        .btn_down    (btn_down),
        .cmd_done    (cmd_done),
        .cmd_blocked (cmd_blocked),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .placed      (placed),
        .busy        (busy)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    task automatic tick();
        @(posedge clka);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int budget, output int when);
        int n;
        n = 0;
        while ((cmd_valid !== 1'b1) && (n < budget)) begin
            tick();
            n++;
        end
        when = cyc;
        check("valid_timeout", {31'd0, cmd_valid}, 32'd1);
    endtask

    task automatic ack(input int delay, input logic blk);
        for (int i = 1; i < delay; i++) tick();
        cmd_done    = 1'b1;
        cmd_blocked = blk;
        tick();
        cmd_done    = 1'b0;
        cmd_blocked = 1'b0;
    endtask

    initial begin
        restart_n = 1'b1;
        fsm_state = GS_GEN;
        {btn_left, btn_right, btn_rot, btn_down} = '0;
        {cmd_done, cmd_blocked} = '0;
        #1 restart_n = 1'b0;
        #1;
        check("rst_valid",  {31'd0, cmd_valid}, 32'd0);
        check("rst_op",     {29'd0, cmd_op},    32'd0);
        check("rst_placed", {31'd0, placed},    32'd0);
        check("rst_busy",   {31'd0, busy},      32'd0);
        tick();
        tick();
        restart_n = 1'b1;
        tick();

        // Gravity alone, datapath acks after 2 cycles: DOWN every 6 cycles
        fsm_state = GS_MOVE;
        t0 = cyc;
        wait_valid(20, at);
        check("grav1_cycle", at, t0 + 7);
        check("grav1_op", {29'd0, cmd_op}, OP_DOWN);
        check("grav1_busy", {31'd0, busy}, 32'd1);
        ack(2, 1'b0);
        check("grav1_placed", {31'd0, placed}, 32'd0);
        check("grav1_gap", {31'd0, cmd_valid}, 32'd0);
        wait_valid(20, at);
        check("grav2_cycle", at, t0 + 13);
        ack(2, 1'b0);
        check("grav2_placed", {31'd0, placed}, 32'd0);
        wait_valid(20, at);
        check("grav3_cycle", at, t0 + 19);
        ack(2, 1'b0);

        // Priority: left + rot pulsed in the cycle gravity wraps
        tick();
        tick();
        check("prio_pre_valid", {31'd0, cmd_valid}, 32'd0);
        btn_left = 1'b1;
        btn_rot  = 1'b1;
        tick();
        btn_left = 1'b0;
        btn_rot  = 1'b0;
        wait_valid(20, at);
        check("prio_down_cycle", at, t0 + 25);
        check("prio_down_op", {29'd0, cmd_op}, OP_DOWN);
        ack(1, 1'b0);
        check("prio_gap1", {31'd0, cmd_valid}, 32'd0);
        check("prio_gap1_op", {29'd0, cmd_op}, OP_NONE);
        wait_valid(20, at);
        check("prio_rot_cycle", at, t0 + 27);
        check("prio_rot_op", {29'd0, cmd_op}, OP_ROT);
        ack(1, 1'b0);
        check("prio_gap2", {31'd0, cmd_valid}, 32'd0);
        wait_valid(20, at);
        check("prio_left_cycle", at, t0 + 29);
        check("prio_left_op", {29'd0, cmd_op}, OP_LEFT);
        ack(1, 1'b0);

        // Landing: blocked DOWN -> placed one cycle after done, then HOLD
        wait_valid(20, at);
        check("land_cycle", at, t0 + 31);
        check("land_op", {29'd0, cmd_op}, OP_DOWN);
        ack(1, 1'b1);
        check("land_placed", {31'd0, placed}, 32'd1);
        check("land_busy", {31'd0, busy}, 32'd1);
        check("land_valid", {31'd0, cmd_valid}, 32'd0);
        check("land_op_none", {29'd0, cmd_op}, OP_NONE);
        btn_right = 1'b1;
        tick();
        btn_right = 1'b0;
        check("land_placed_pulse", {31'd0, placed}, 32'd0);
        check("hold_busy1", {31'd0, busy}, 32'd1);
        tick();
        tick();
        tick();
        check("hold_valid", {31'd0, cmd_valid}, 32'd0);
        check("hold_busy2", {31'd0, busy}, 32'd1);
        fsm_state = GS_LAND;
        tick();
        check("land_exit_busy", {31'd0, busy}, 32'd0);
        tick();
        tick();
        check("land_exit_valid", {31'd0, cmd_valid}, 32'd0);

        // Leaving MOVE mid-ISSUE: command completes, no placed, pending cleared
        fsm_state = GS_MOVE;
        m0 = cyc;
        wait_valid(20, at);
        check("exit_cycle", at, m0 + 7);
        btn_rot = 1'b1;
        tick();
        btn_rot = 1'b0;
        fsm_state = GS_GAMEOVER;
        tick();
        check("exit_valid_held", {31'd0, cmd_valid}, 32'd1);
        check("exit_op_held", {29'd0, cmd_op}, OP_DOWN);
        ack(1, 1'b1);
        check("exit_valid_drop", {31'd0, cmd_valid}, 32'd0);
        check("exit_no_placed", {31'd0, placed}, 32'd0);
        check("exit_busy", {31'd0, busy}, 32'd0);
        tick();
        check("exit_no_placed2", {31'd0, placed}, 32'd0);
        fsm_state = GS_MOVE;
        g0 = cyc;
        tick();
        tick();
        check("exit_pend_cleared", {31'd0, cmd_valid}, 32'd0);

        // Asynchronous reset in the middle of ISSUE
        wait_valid(20, at);
        check("areset_pre_cycle", at, g0 + 7);
        #3 restart_n = 1'b0;
        #1;
        check("areset_valid", {31'd0, cmd_valid}, 32'd0);
        check("areset_op", {29'd0, cmd_op}, OP_NONE);
        check("areset_busy", {31'd0, busy}, 32'd0);
        tick();
        restart_n = 1'b1;
        fsm_state = GS_GEN;
        tick();

        // Requests outside MOVE never issue
        btn_left = 1'b1;
        tick();
        btn_left  = 1'b0;
        btn_right = 1'b1;
        tick();
        btn_right = 1'b0;
        fsm_state = GS_MOVE;
        g1 = cyc;
        tick();
        check("outside_move_1", {31'd0, cmd_valid}, 32'd0);
        tick();
        check("outside_move_2", {31'd0, cmd_valid}, 32'd0);

        // btn_down coinciding with gravity wrap: a single DOWN
        tick();
        tick();
        tick();
        btn_down = 1'b1;
        tick();
        btn_down = 1'b0;
        check("coll_pre_valid", {31'd0, cmd_valid}, 32'd0);
        tick();
        check("coll_valid", {31'd0, cmd_valid}, 32'd1);
        check("coll_op", {29'd0, cmd_op}, OP_DOWN);
        check("coll_cycle", cyc, g1 + 7);
        ack(1, 1'b0);
        check("coll_gap", {31'd0, cmd_valid}, 32'd0);
        tick();
        check("coll_single1", {31'd0, cmd_valid}, 32'd0);
        tick();
        check("coll_single2", {31'd0, cmd_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
